// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and widths for the Sobel memory arbiter.
package sobel_pkg;
    localparam int ADDR_W = 32;
    localparam int WIN_W  = 72;
    localparam int GRAD_W = 16;
    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, DONE} state_t;
    typedef enum logic {CH_RD, CH_WR} ch_t;
endpackage

// File: rtl/sobel_mem_arbiter.sv
// sobel_mem_arbiter: round-robin arbiter giving a window-read and a gradient-write
// channel turns on one shared memory port, with a per-access timeout.
module sobel_mem_arbiter
    import sobel_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [WIN_W-1:0]  rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [GRAD_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [GRAD_W-1:0] mem_wdata,
    input  logic [WIN_W-1:0]  mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);
    state_t            state, nxt;
    ch_t               last_grant, grant_n;
    logic [15:0]       cnt, cnt_n;
    logic [ADDR_W-1:0] addr_n;
    logic [GRAD_W-1:0] wdata_n;
    logic [WIN_W-1:0]  rd_data_n;
    logic              set_err;

    always_comb begin
        nxt       = state;
        grant_n   = last_grant;
        cnt_n     = cnt;
        addr_n    = mem_addr;
        wdata_n   = mem_wdata;
        rd_data_n = rd_data;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req && (!wr_req || last_grant == CH_WR)) begin
                    nxt     = RD_BUSY;
                    grant_n = CH_RD;
                    addr_n  = rd_addr;
                    cnt_n   = '0;
                end else if (wr_req) begin
                    nxt     = WR_BUSY;
                    grant_n = CH_WR;
                    addr_n  = wr_addr;
                    wdata_n = wr_data;
                    cnt_n   = '0;
                end
            end
            RD_BUSY, WR_BUSY: begin
                cnt_n = cnt + 16'd1;
                // a completing ack beats a timeout landing on the same cycle
                if (mem_ack) begin
                    nxt       = DONE;
                    rd_data_n = state == RD_BUSY ? mem_rdata : rd_data;
                end else if (cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                    nxt       = DONE;
                    set_err   = 1'b1;
                    rd_data_n = state == RD_BUSY ? '0 : rd_data;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= CH_WR;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_data     <= '0;
            rd_ack      <= 1'b0;
            wr_ack      <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= nxt;
            last_grant  <= grant_n;
            cnt         <= cnt_n;
            mem_req     <= nxt == RD_BUSY || nxt == WR_BUSY;
            mem_we      <= nxt == WR_BUSY;
            mem_addr    <= addr_n;
            mem_wdata   <= wdata_n;
            rd_data     <= rd_data_n;
            rd_ack      <= nxt == DONE && state == RD_BUSY;
            wr_ack      <= nxt == DONE && state == WR_BUSY;
            busy        <= nxt != IDLE;
            timeout_err <= set_err || (timeout_err && !err_clr);
        end
    end
endmodule

// File: tb/tb_sobel_mem_arbiter.sv
// tb_sobel_mem_arbiter: directed and randomized accesses checked against a
// transaction-level model of grant order, acks, read data and the error flag.
module tb_sobel_mem_arbiter;
    import sobel_pkg::*;
    localparam int TO = 8;

    logic        clk = 0, rst_n = 0;
    logic        rd_req = 0, wr_req = 0, mem_ack = 0, err_clr = 0;
    logic [31:0] rd_addr = 0, wr_addr = 0;
    logic [15:0] wr_data = 0;
    logic [71:0] mem_rdata = 0;
    logic        rd_ack, wr_ack, mem_req, mem_we, busy, timeout_err;
    logic [71:0] rd_data;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;

    int   vectors = 0, miscompares = 0;
    ch_t  last_ch = CH_WR;
    logic exp_err = 0;
    logic [71:0] exp_rd = 0;

    sobel_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access: lat<TO acks after lat waiting cycles, otherwise times out.
    task automatic access(input int lat, input bit clr_after);
        ch_t ch;
        logic [31:0] a;
        logic [15:0] d;
        logic [71:0] rdat;
        int waits = 0;
        ch = (rd_req && (!wr_req || last_ch == CH_WR)) ? CH_RD : CH_WR;
        last_ch = ch;
        a = ch == CH_RD ? rd_addr : wr_addr;
        d = wr_data;
        while (!mem_req && waits < 6) begin
            step();
            waits++;
        end
        chk("grant_lat", 72'(waits), 72'd1);
        chk("mem_we", 72'(mem_we), 72'(ch == CH_WR));
        chk("mem_addr", 72'(mem_addr), 72'(a));
        if (ch == CH_WR) chk("mem_wdata", 72'(mem_wdata), 72'(d));
        rd_addr = $urandom;
        wr_addr = $urandom;
        wr_data = 16'($urandom);
        if (lat < TO) begin
            repeat (lat) begin
                step();
                chk("hold_req", 72'(mem_req), 72'd1);
                chk("hold_addr", 72'(mem_addr), 72'(a));
            end
            mem_ack = 1;
            rdat = {$urandom, $urandom, 8'($urandom)};
            mem_rdata = rdat;
            step();
            mem_ack = 0;
            if (ch == CH_RD) exp_rd = rdat;
        end else begin
            repeat (TO - 1) begin
                step();
                chk("to_hold_req", 72'(mem_req), 72'd1);
            end
            err_clr = 1'($urandom);
            step();
            err_clr = 0;
            exp_err = 1;
            if (ch == CH_RD) exp_rd = '0;
        end
        chk("done_mem_req", 72'(mem_req), 72'd0);
        chk("rd_ack", 72'(rd_ack), 72'(ch == CH_RD));
        chk("wr_ack", 72'(wr_ack), 72'(ch == CH_WR));
        chk("rd_data", rd_data, exp_rd);
        chk("err_done", 72'(timeout_err), 72'(exp_err));
        chk("busy_done", 72'(busy), 72'd1);
        if (ch == CH_RD) rd_req = 0; else wr_req = 0;
        err_clr = clr_after;
        mem_ack = 1'($urandom);
        step();
        err_clr = 0;
        mem_ack = 0;
        if (clr_after) exp_err = 0;
        chk("idle_busy", 72'(busy), 72'd0);
        chk("idle_acks", 72'({rd_ack, wr_ack, mem_req}), 72'd0);
        chk("idle_err", 72'(timeout_err), 72'(exp_err));
        chk("idle_rd_data", rd_data, exp_rd);
    endtask

    initial begin
        int n;
        step();
        chk("rst_ctl", 72'({mem_req, mem_we, rd_ack, wr_ack, busy, timeout_err}), 72'd0);
        chk("rst_data", {mem_addr, mem_wdata, 24'd0} | rd_data, 72'd0);
        rst_n = 1;
        // tie right after reset: read first, then the held write directly after
        rd_req = 1; rd_addr = 32'h100;
        wr_req = 1; wr_addr = 32'h2000; wr_data = 16'h00FF;
        access(3, 0);
        chk("tie_last", 72'(last_ch), 72'(CH_RD));
        wr_addr = 32'h2000; wr_data = 16'h00FF;
        access(1, 0);
        // both held continuously: grants alternate
        for (int i = 0; i < 6; i++) begin
            rd_req = 1;
            wr_req = 1;
            access($urandom_range(0, TO - 1), 0);
            chk("alt", 72'(last_ch), 72'(i % 2 == 0 ? CH_RD : CH_WR));
        end
        // timeout on a read, then clear the flag
        rd_req = 1;
        access(TO, 0);
        chk("sticky", 72'(timeout_err), 72'd1);
        err_clr = 1;
        step();
        err_clr = 0;
        exp_err = 0;
        chk("err_clr", 72'(timeout_err), 72'd0);
        // reset in the middle of a write
        wr_req = 1;
        n = 0;
        while (!mem_req && n < 6) begin
            step();
            n++;
        end
        chk("wr_busy_we", 72'(mem_we), 72'd1);
        #2 rst_n = 0;
        #1;
        chk("async_mem_req", 72'(mem_req), 72'd0);
        chk("async_busy", 72'(busy), 72'd0);
        repeat (3) begin
            step();
            chk("rst_no_wr_ack", 72'(wr_ack), 72'd0);
        end
        rst_n = 1;
        last_ch = CH_WR;
        exp_rd = '0;
        exp_err = 0;
        rd_req = 1;
        access(2, 0);
        chk("post_rst_tie", 72'(last_ch), 72'(CH_RD));
        access(0, 0);
        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (!rd_req && !wr_req) begin
                rd_req = 1'($urandom);
                wr_req = !rd_req || 1'($urandom);
            end else begin
                if (!rd_req) rd_req = 1'($urandom);
                if (!wr_req) wr_req = 1'($urandom);
            end
            access($urandom_range(0, TO + 1), 1'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sobel_mem_arbiter.md
SOBEL_MEM_ARBITER -- requirements
Module: sobel_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024; maximum cycles a granted access waits for mem_ack before abort.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rd_req  input  1  read channel request; level, held until rd_ack.
REQ-005 rd_addr  input  32  read byte address.
REQ-006 rd_ack  output  1  one-cycle read completion pulse.
REQ-007 rd_data  output  72  read data (3x3 window), valid while rd_ack=1.
REQ-008 wr_req  input  1  write channel request; level, held until wr_ack.
REQ-009 wr_addr  input  32  write byte address.
REQ-010 wr_data  input  16  write data (gradient).
REQ-011 wr_ack  output  1  one-cycle write completion pulse.
REQ-012 mem_req  output  1  shared memory port request.
REQ-013 mem_we  output  1  1=write, 0=read; valid while mem_req=1.
REQ-014 mem_addr  output  32  memory address, stable while mem_req=1.
REQ-015 mem_wdata  output  16  memory write data, stable while mem_req=1.
REQ-016 mem_rdata  input  72  memory read data, sampled on mem_ack.
REQ-017 mem_ack  input  1  memory completion.
REQ-018 busy  output  1  1 in any state except IDLE.
REQ-019 timeout_err  output  1  sticky abort flag.
REQ-020 err_clr  input  1  clears timeout_err.

Function
REQ-021 FSM states: IDLE, RD_BUSY, WR_BUSY, DONE; all outputs registered.
REQ-022 IDLE: rd_req only -> RD_BUSY; wr_req only -> WR_BUSY; both -> channel not in last_grant; none -> stay.
REQ-023 On grant, rd_addr or wr_addr/wr_data latch; mem_req=1 first cycle after grant edge; last_grant updates to granted channel.
REQ-024 RD_BUSY/WR_BUSY: mem_req=1, mem_we=0/1, address/data constant until exit.
REQ-025 mem_ack=1 in busy state -> DONE next cycle; mem_req=0 that cycle; rd_data latches mem_rdata (read only); matching rd_ack or wr_ack =1 for exactly the DONE cycle.
REQ-026 Fastest access: request at edge N, mem_req high N+1, mem_ack N+1, ack pulse N+2, IDLE N+3.
REQ-027 DONE always -> IDLE after one cycle; requests ignored in DONE so held req is not re-granted.
REQ-028 mem_ack in IDLE or DONE ignored, no output change.
REQ-029 16-bit wait counter clears on grant, increments each busy cycle without mem_ack; reaching TIMEOUT_CYCLES -> DONE, timeout_err=1, ack still pulsed, rd_data=0 on aborted read.
REQ-030 Requests never dropped: a requester losing a tie is granted at the next IDLE if still asserted.
REQ-031 err_clr clears timeout_err next cycle; simultaneous timeout and err_clr -> timeout_err=1.

Reset
REQ-032 rst_n low: state IDLE; mem_req, mem_we, rd_ack, wr_ack, busy, timeout_err = 0; mem_addr, mem_wdata, rd_data, counter = 0; last_grant = WR (read wins first tie).
REQ-033 Reset mid-access aborts without ack; mem_req drops asynchronously.

Structure
REQ-034 Shared package sobel_pkg holds state enum, channel enum {CH_RD, CH_WR}, and widths ADDR_W=32, WIN_W=72, GRAD_W=16.
REQ-035 Single module; no sub-modules.

Verification
REQ-036 rd_req, rd_addr=0x100, mem_ack 3 cycles later -> mem_addr=0x100, mem_we=0, rd_ack one cycle, rd_data=mem_rdata.
REQ-037 rd_req and wr_req same cycle after reset -> read first; wr_addr=0x2000, wr_data=0x00FF issued directly after DONE, mem_we=1.
REQ-038 Both held continuously for 6 accesses -> grants alternate RD,WR,RD,WR,RD,WR.
REQ-039 TIMEOUT_CYCLES=8, no mem_ack -> mem_req low after 8 busy cycles, timeout_err=1, ack pulsed, rd_data=0; err_clr -> timeout_err=0.
REQ-040 rst_n low in WR_BUSY -> mem_req=0 immediately, no wr_ack; after release, first tie grants read.
